// File: rtl/pacote_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Segment vectors are ordered a..g with segment a in bit 6.
package pacote_display_pkg;

  typedef enum logic [1:0] {
    DESLIGADO = 2'd0,
    APAGADO   = 2'd1,
    EXIBINDO  = 2'd2
  } estado_t;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_APAGADO = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_ERRO    = 7'b0110000;

  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controlador_varredura_display_decodificador.sv
// BCD to 7-segment decoder, purely combinational, active-high segments.
// Codes 10..15 produce the error pattern.
module decodificador_bcd_para_display_sete_segmentos
  import pacote_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] segmentos_o
);

  always_comb begin
    segmentos_o = SEG_ERRO;
    case (bcd_i)
      4'd0: segmentos_o = 7'b1111110;
      4'd1: segmentos_o = 7'b0110000;
      4'd2: segmentos_o = 7'b1101101;
      4'd3: segmentos_o = 7'b1111001;
      4'd4: segmentos_o = 7'b0110011;
      4'd5: segmentos_o = 7'b1011011;
      4'd6: segmentos_o = 7'b1011111;
      4'd7: segmentos_o = 7'b1110000;
      4'd8: segmentos_o = 7'b1111111;
      4'd9: segmentos_o = 7'b1111011;
      default: segmentos_o = SEG_ERRO;
    endcase
  end

endmodule

// File: rtl/controlador_varredura_display.sv
// Scans NUM_DIGITOS common-cathode digits with a blank gap between digits; double-buffered BCD input.
// Optional SUPRESSAO_ZEROS_EN blanks leading zeros (digit 0 always shown).
module controlador_varredura_display
  import pacote_display_pkg::*;
#(
  parameter int NUM_DIGITOS   = 4,
  parameter int DIVISOR       = 50000,
  parameter int TEMPO_APAGADO = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         habilita,
  input  logic                         atualiza,
  input  logic [BCD_W*NUM_DIGITOS-1:0] valores,
  output logic [SEG_W-1:0]             segmentos,
  output logic [NUM_DIGITOS-1:0]       seleciona,
  output logic                         fim_varredura
);

  localparam int CNT_W = $clog2(maximo(DIVISOR, TEMPO_APAGADO));
  localparam int IDX_W = $clog2(NUM_DIGITOS);
  localparam int DAT_W = BCD_W * NUM_DIGITOS;
  localparam logic [CNT_W-1:0] FIM_EXIBE  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] FIM_APAGA  = CNT_W'(TEMPO_APAGADO - 1);
  localparam logic [IDX_W-1:0] ULTIMO_DIG = IDX_W'(NUM_DIGITOS - 1);

  estado_t                estado_q, estado_d;
  logic [CNT_W-1:0]       contador_q, contador_d;
  logic [IDX_W-1:0]       indice_q, indice_d;
  logic [DAT_W-1:0]       shadow_q, shadow_d;
  logic [DAT_W-1:0]       ativo_q, ativo_d;
  logic [SEG_W-1:0]       segmentos_q, segmentos_d;
  logic [NUM_DIGITOS-1:0] seleciona_q, seleciona_d;
  logic                   fim_q, fim_d;
  logic                   carrega;
  logic [BCD_W-1:0]       bcd_atual;
  logic [SEG_W-1:0]       seg_decod;
  logic [NUM_DIGITOS-1:0] apagar;

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q + 1'b1;
    indice_d   = indice_q;
    shadow_d   = atualiza ? valores : shadow_q;
    ativo_d    = ativo_q;
    fim_d      = 1'b0;
    carrega    = 1'b0;
    if (!habilita) begin
      estado_d   = DESLIGADO;
      contador_d = '0;
      indice_d   = '0;
    end else begin
      case (estado_q)
        DESLIGADO: begin
          estado_d   = APAGADO;
          contador_d = '0;
          carrega    = 1'b1;
        end
        APAGADO: begin
          if (contador_q == FIM_APAGA) begin
            estado_d   = EXIBINDO;
            contador_d = '0;
          end
        end
        EXIBINDO: begin
          if (contador_q == FIM_EXIBE) begin
            estado_d   = APAGADO;
            contador_d = '0;
            if (indice_q == ULTIMO_DIG) begin
              indice_d = '0;
              fim_d    = 1'b1;
              carrega  = 1'b1;
            end else begin
              indice_d = indice_q + 1'b1;
            end
          end
        end
        default: begin
          estado_d   = DESLIGADO;
          contador_d = '0;
          indice_d   = '0;
        end
      endcase
    end
    // A strobe coinciding with the frame swap goes straight to the active buffer.
    if (carrega) ativo_d = atualiza ? valores : shadow_q;
  end

  assign bcd_atual = ativo_d[BCD_W*int'(indice_d) +: BCD_W];

  decodificador_bcd_para_display_sete_segmentos u_decod (
    .bcd_i       (bcd_atual),
    .segmentos_o (seg_decod)
  );

`ifdef SUPRESSAO_ZEROS_EN
  logic zeros_acima;

  always_comb begin
    zeros_acima = 1'b1;
    apagar      = '0;
    for (int i = NUM_DIGITOS - 1; i > 0; i--) begin
      zeros_acima = zeros_acima && (ativo_d[BCD_W*i +: BCD_W] == '0);
      apagar[i]   = zeros_acima;
    end
  end
`else
  assign apagar = '0;
`endif

  always_comb begin
    seleciona_d = '0;
    segmentos_d = SEG_APAGADO;
    if (estado_d == EXIBINDO) begin
      seleciona_d = NUM_DIGITOS'(1) << indice_d;
      segmentos_d = apagar[indice_d] ? SEG_APAGADO : seg_decod;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q    <= DESLIGADO;
      contador_q  <= '0;
      indice_q    <= '0;
      shadow_q    <= '0;
      ativo_q     <= '0;
      segmentos_q <= SEG_APAGADO;
      seleciona_q <= '0;
      fim_q       <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      contador_q  <= contador_d;
      indice_q    <= indice_d;
      shadow_q    <= shadow_d;
      ativo_q     <= ativo_d;
      segmentos_q <= segmentos_d;
      seleciona_q <= seleciona_d;
      fim_q       <= fim_d;
    end
  end

  assign segmentos     = segmentos_q;
  assign seleciona     = seleciona_q;
  assign fim_varredura = fim_q;

endmodule

// File: tb/tb_controlador_varredura_display.sv
// Scoreboard bench: a frame-time reference model pushes the expected outputs per edge,
// a negedge monitor pops and compares them against the display pins.
module tb_controlador_varredura_display;

  localparam int N = 4;
  localparam int D = 4;
  localparam int T = 2;
  localparam int F = N * (D + T);

  logic            clock;
  logic            reset_n;
  logic            habilita;
  logic            atualiza;
  logic [4*N-1:0]  valores;
  logic [6:0]      segmentos;
  logic [N-1:0]    seleciona;
  logic            fim_varredura;

  controlador_varredura_display #(
    .NUM_DIGITOS   (N),
    .DIVISOR       (D),
    .TEMPO_APAGADO (T)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .habilita      (habilita),
    .atualiza      (atualiza),
    .valores       (valores),
    .segmentos     (segmentos),
    .seleciona     (seleciona),
    .fim_varredura (fim_varredura)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: time since the scan was (re)started, and both buffers.
  bit             ligado;
  int             t;
  logic [4*N-1:0] shadow_m;
  logic [4*N-1:0] ativo_m;

  logic [11:0] fila[$];
  int vetores;
  int erros;

  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0110000;
    endcase
  endfunction

  function automatic bit digito_oculto(input logic [4*N-1:0] a, input int dig);
`ifdef SUPRESSAO_ZEROS_EN
    return (dig > 0) && ((a >> (4 * dig)) == '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int digito_na_tela();
    int p;
    p = t % F;
    if (ligado && (p % (D + T)) >= T) return p / (D + T);
    return -1;
  endfunction

  task automatic passo(input logic r, input logic h, input logic a, input logic [4*N-1:0] v);
    logic [6:0]   seg;
    logic [N-1:0] sel;
    logic         fim;
    int           dig;
    reset_n  = r;
    habilita = h;
    atualiza = a;
    valores  = v;
    if (!r) begin
      ligado = 0; t = 0; shadow_m = '0; ativo_m = '0;
    end else begin
      if (!h) begin
        ligado = 0; t = 0;
      end else if (!ligado) begin
        ligado = 1; t = 0;
        ativo_m = a ? v : shadow_m;
      end else begin
        t++;
        if (t % F == 0) ativo_m = a ? v : shadow_m;
      end
      if (a) shadow_m = v;
    end
    seg = '0; sel = '0; fim = 1'b0;
    dig = digito_na_tela();
    if (dig >= 0) begin
      sel = N'(1) << dig;
      seg = digito_oculto(ativo_m, dig) ? 7'b0 : dec(ativo_m[4*dig +: 4]);
    end
    if (ligado && t > 0 && t % F == 0) fim = 1'b1;
    fila.push_back({seg, sel, fim});
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    logic [11:0] esp;
    forever begin
      @(negedge clock);
      if (fila.size() > 0) begin
        esp = fila.pop_front();
        vetores++;
        if ({segmentos, seleciona, fim_varredura} !== esp) begin
          erros++;
          $display("FAIL saida t=%0t: seg=%b sel=%b fim=%b, esperado seg=%b sel=%b fim=%b",
                   $time, segmentos, seleciona, fim_varredura, esp[11:5], esp[4:1], esp[0]);
        end
      end
    end
  end

  task automatic ate_digito(input int alvo);
    for (int k = 0; k < 2 * F && digito_na_tela() != alvo; k++) passo(1, 1, 0, '0);
  endtask

  initial begin : estimulo
    logic r, h, a;
    logic [4*N-1:0] v;
    vetores = 0; erros = 0;
    ligado = 0; t = 0; shadow_m = '0; ativo_m = '0;
    reset_n = 0; habilita = 0; atualiza = 0; valores = '0;

    repeat (3) passo(0, 1, 0, '0);
    passo(1, 0, 1, 16'h1234);
    repeat (60) passo(1, 1, 0, '0);
    ate_digito(1);
    passo(1, 1, 1, 16'h9876);
    repeat (60) passo(1, 1, 0, '0);
    passo(1, 1, 1, 16'hFA05);
    repeat (50) passo(1, 1, 0, '0);
    ate_digito(2);
    repeat (3) passo(1, 0, 0, '0);
    repeat (30) passo(1, 1, 0, '0);
    ate_digito(2);
    passo(0, 1, 0, '0);
    repeat (30) passo(1, 1, 0, '0);
    passo(1, 1, 1, 16'h0050);
    repeat (60) passo(1, 1, 0, '0);
    passo(1, 1, 1, 16'h0000);
    repeat (60) passo(1, 1, 0, '0);

    repeat (800) begin
      r = ($urandom_range(0, 99) != 0);
      h = ($urandom_range(0, 39) != 0);
      a = ($urandom_range(0, 9) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < N; i++)
          if (v[4*i +: 4] > 4'd9) v[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) v[4*N-1 -: 8] = 8'h00;
      passo(r, h, a, v);
    end

    for (int k = 0; k < 10 && fila.size() > 0; k++) @(posedge clock);
    if (fila.size() > 0) begin
      erros++;
      $display("FAIL drenagem: %0d esperados pendentes, requerido 0", fila.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
